// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage and its users.
// Per-boundary width defaults let each stage instantiate the block without magic numbers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  localparam int CTRL_WRITE_MEM = 0;
  localparam int CTRL_WRITE_REG = 1;
  localparam int CTRL_READ_MEM  = 2;

  localparam int PIPE_CTRL_W  = 3;
  localparam int IF_ID_DATA_W  = 16;
  localparam int ID_EX_DATA_W  = 35;
  localparam int EX_MEM_DATA_W = 35;
  localparam int MEM_WB_DATA_W = 35;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating 16-bit event counter with synchronous clear.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake, 2-entry skid buffer, flush, bubble zeroing.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W     = 3,
  parameter int                 DATA_W     = 35,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
`endif
);

  pipe_state_t       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_fire, out_fire;

  // in_ready depends only on registered state and flush, never on out_ready.
  assign in_ready  = rst_n & (state_q != ST_SKID) & ~flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d     = ST_FULL;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = ST_SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d     = ST_FULL;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= RESET_DATA;
      skid_ctrl_q <= '0;
      skid_data_q <= RESET_DATA;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .clr   (flush),
    .count (stall_cnt)
  );

  pipe_perf_cnt u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid),
    .clr   (flush),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: accepted payloads are queued, a monitor checks deliveries.
// Perf-counter checks are compiled only when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int CW = 3;
  localparam int DW = 35;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } pl_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, bubble_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  pl_t  exp_q[$];
  pl_t  exp_e;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .RESET_DATA('0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Expected payloads enter the scoreboard at the cycle they are accepted.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(pl_t'{in_ctrl, in_data});
  end

  // Monitor: every delivery must match the oldest outstanding payload.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %0h expected no delivery", out_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("mon_data", 64'(out_data), 64'(exp_e.d));
          check("mon_ctrl", 64'(out_ctrl), 64'(exp_e.c));
        end
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    // Reset values
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..20 with one-cycle latency and no gaps
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 3'(i), 35'(i), 1'b1, 1'b0);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(i));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check("stream_drain_valid", 64'(out_valid), 64'd0);
    check("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);

    // Backpressure: A then B fill main and skid
    drive(1'b1, 3'b101, 35'h1_2345_6789, 1'b0, 1'b0);
    step();
    check("bp_full_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 3'b010, 35'h0_0BAD_CAFE, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check("bp_skid_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_data", 64'(out_data), 64'h1_2345_6789);
    check("bp_hold_ctrl", 64'(out_ctrl), 64'b101);
    step();
    step();
    check("bp_stable_data", 64'(out_data), 64'h1_2345_6789);
    out_ready = 1'b1;
    #1;
    check("bp_no_ready_path", 64'(in_ready), 64'd0);
    step();
    check("bp_after_a_ready", 64'(in_ready), 64'd1);
    check("bp_b_data", 64'(out_data), 64'h0_0BAD_CAFE);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush from SKID, with a delivery and an offered input in the flush cycle
    drive(1'b1, 3'b111, 35'h0_1111_1111, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b111, 35'h0_2222_2222, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b111, 35'h0_3333_3333, 1'b1, 1'b1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_pre_ctrl", 64'(out_ctrl), 64'b111);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_data_hold", 64'(out_data), 64'h0_1111_1111);
    step();
    check("flush_no_capture", 64'(out_valid), 64'd0);

    // Simultaneous in_fire and out_fire while FULL
    drive(1'b1, 3'b001, 35'h4_0000_0001, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b100, 35'h4_0000_0002, 1'b1, 1'b0);
    check("simul_in_ready", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    check("simul_valid", 64'(out_valid), 64'd1);
    check("simul_data", 64'(out_data), 64'h4_0000_0002);
    check("simul_not_skid", 64'(in_ready), 64'd1);
    step();

    // Reset mid-stream while in SKID
    drive(1'b1, 3'b011, 35'h5_5555_5555, 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b110, 35'h6_6666_6666, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ctrl", 64'(out_ctrl), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_release_ready", 64'(in_ready), 64'd1);
    check("midrst_still_empty", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b1, 3'b010, 35'h7_0000_0007, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (5) step();
    check("perf_stall5", 64'(stall_cnt), 64'd5);
    check("perf_bubble1", 64'(bubble_cnt), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_stall_clr", 64'(stall_cnt), 64'd0);
    check("perf_bubble_clr", 64'(bubble_cnt), 64'd0);
    drive(1'b1, 3'b001, 35'h7_0000_0008, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (70000) step();
    check("perf_stall_sat", 64'(stall_cnt), 64'hFFFF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
